// File: rtl/mdr_access_sequencer_pkg.sv
// Shared types for the MDR/MAR access sequencer: FSM states, operation
// codes, MDR input select constants and the Moore output decode.
package mdr_access_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WR_LOAD = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_CAPT = 3'd4,
    ST_WR_WAIT = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // MDR input select: memory data-in versus the internal bus.
  localparam logic SEL_MEM = 1'b1;
  localparam logic SEL_BUS = 1'b0;

  typedef struct packed {
    logic mar_in;
    logic mdr_en;
    logic mdr_read;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
    logic err;
  } outs_t;

  // Pure function of state so the outputs carry no input dependence.
  function automatic outs_t decode_outputs(input state_e s);
    outs_t o;
    o = '0;
    case (s)
      ST_IDLE: begin
        o = '0;
      end
      ST_ADDR: begin
        o.mar_in = 1'b1;
        o.busy   = 1'b1;
      end
      ST_WR_LOAD: begin
        o.mdr_en   = 1'b1;
        o.mdr_read = SEL_BUS;
        o.busy     = 1'b1;
      end
      ST_RD_WAIT: begin
        o.mem_rd = 1'b1;
        o.busy   = 1'b1;
      end
      ST_RD_CAPT: begin
        o.mdr_en   = 1'b1;
        o.mdr_read = SEL_MEM;
        o.busy     = 1'b1;
      end
      ST_WR_WAIT: begin
        o.mem_wr = 1'b1;
        o.busy   = 1'b1;
      end
      ST_DONE: begin
        o.done = 1'b1;
        o.busy = 1'b1;
      end
      ST_ERR: begin
        o.err  = 1'b1;
        o.busy = 1'b1;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mdr_access_sequencer_if.sv
// Control-unit / memory-side handshake bundle of the access sequencer.
// CNT_W must equal the sequencer's $clog2(TIMEOUT+1).
interface mdr_access_sequencer_if #(
  parameter int CNT_W = 5
);

  logic             rd_req;
  logic             wr_req;
  logic             mem_ready;
  logic             mar_in;
  logic             mdr_en;
  logic             mdr_read;
  logic             mem_rd;
  logic             mem_wr;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] wait_cnt;

  // Requester / memory side.
  modport master (
    output rd_req, wr_req, mem_ready,
    input  mar_in, mdr_en, mdr_read, mem_rd, mem_wr, busy, done, err, wait_cnt
  );

  // Sequencer side.
  modport slave (
    input  rd_req, wr_req, mem_ready,
    output mar_in, mdr_en, mdr_read, mem_rd, mem_wr, busy, done, err, wait_cnt
  );

endinterface

// File: rtl/mdr_access_sequencer_wait_timer.sv
// Wait-state counter: synchronous clear, count enable, saturation at
// TIMEOUT and an expire flag raised on the last allowed wait cycle.
module mdr_access_sequencer_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign expire_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_access_sequencer.sv
// MAR/MDR access sequencer: turns one-cycle read/write requests into the
// MAR load, MDR load/select and memory strobe sequence, waits on mem_ready
// and reports done or a timeout error.
module mdr_access_sequencer
  import mdr_access_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   clr,
  mdr_access_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q;
  state_e           state_d;
  op_e              op_q;
  op_e              op_d;
  outs_t            outs_q;
  logic             in_wait_s;
  logic             tmr_clear_s;
  logic             tmr_en_s;
  logic             expire_s;
  logic [CNT_W-1:0] cnt_s;

  assign in_wait_s = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);

  // Next state and latched operation; read wins over a simultaneous write.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.rd_req) begin
          state_d = ST_ADDR;
          op_d    = OP_RD;
        end else if (bus.wr_req) begin
          state_d = ST_ADDR;
          op_d    = OP_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (op_q == OP_RD) begin
          state_d = ST_RD_WAIT;
        end else begin
          state_d = ST_WR_LOAD;
        end
      end
      ST_WR_LOAD: begin
        state_d = ST_WR_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.mem_ready) begin
          state_d = ST_RD_CAPT;
        end else if (expire_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_CAPT: begin
        state_d = ST_DONE;
      end
      ST_WR_WAIT: begin
        if (bus.mem_ready) begin
          state_d = ST_DONE;
        end else if (expire_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Timer is zeroed while heading for IDLE and in the cycle before a wait
  // state is entered; it counts only wait cycles that lack mem_ready.
  always_comb begin
    tmr_clear_s = (state_d == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_WR_LOAD);
    tmr_en_s    = in_wait_s && !bus.mem_ready;
  end

  // State and operation registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Outputs registered from the decode of the next state, so they equal
  // the Moore decode of the current state while coming straight from flops.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      outs_q <= '0;
    end else begin
      outs_q <= decode_outputs(state_d);
    end
  end

  mdr_access_sequencer_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (clr),
    .clear_i  (tmr_clear_s),
    .enable_i (tmr_en_s),
    .cnt_o    (cnt_s),
    .expire_o (expire_s)
  );

  assign bus.mar_in   = outs_q.mar_in;
  assign bus.mdr_en   = outs_q.mdr_en;
  assign bus.mdr_read = outs_q.mdr_read;
  assign bus.mem_rd   = outs_q.mem_rd;
  assign bus.mem_wr   = outs_q.mem_wr;
  assign bus.busy     = outs_q.busy;
  assign bus.done     = outs_q.done;
  assign bus.err      = outs_q.err;
  assign bus.wait_cnt = cnt_s;

endmodule

// File: tb/tb_mdr_access_sequencer.sv
// Scoreboard bench for mdr_access_sequencer. Instance A uses TIMEOUT=4,
// instance B uses TIMEOUT=2. Each step queues (inputs, expected outputs of
// the next cycle, expected wait_cnt or -1 for don't-care).
module tb_mdr_access_sequencer;

  localparam int TO_A = 4;
  localparam int CW_A = $clog2(TO_A + 1);
  localparam int TO_B = 2;
  localparam int CW_B = $clog2(TO_B + 1);

  // Output vector {mar_in, mdr_en, mdr_read, mem_rd, mem_wr, busy, done, err}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_ADDR = 8'b1000_0100;
  localparam logic [7:0] V_WRLD = 8'b0100_0100;
  localparam logic [7:0] V_RDW  = 8'b0001_0100;
  localparam logic [7:0] V_RDC  = 8'b0110_0100;
  localparam logic [7:0] V_WRW  = 8'b0000_1100;
  localparam logic [7:0] V_DONE = 8'b0000_0110;
  localparam logic [7:0] V_ERR  = 8'b0000_0101;

  typedef struct {
    bit         rd;
    bit         wr;
    bit         rdy;
    logic [7:0] exp;
    int         cnt;
  } step_t;

  logic  clk;
  logic  clr;
  int    errors;
  int    checks;
  step_t sq[$];

  mdr_access_sequencer_if #(.CNT_W(CW_A)) a_if ();
  mdr_access_sequencer_if #(.CNT_W(CW_B)) b_if ();

  mdr_access_sequencer #(.TIMEOUT(TO_A)) dut_a (.clk(clk), .clr(clr), .bus(a_if.slave));
  mdr_access_sequencer #(.TIMEOUT(TO_B)) dut_b (.clk(clk), .clr(clr), .bus(b_if.slave));

  logic [7:0] obs_a;
  logic [7:0] obs_b;
  assign obs_a = {a_if.mar_in, a_if.mdr_en, a_if.mdr_read, a_if.mem_rd,
                  a_if.mem_wr, a_if.busy, a_if.done, a_if.err};
  assign obs_b = {b_if.mar_in, b_if.mdr_en, b_if.mdr_read, b_if.mem_rd,
                  b_if.mem_wr, b_if.busy, b_if.done, b_if.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(bit rd, bit wr, bit rdy, logic [7:0] exp, int cnt);
    step_t s;
    s.rd = rd; s.wr = wr; s.rdy = rdy; s.exp = exp; s.cnt = cnt;
    sq.push_back(s);
  endfunction

  task automatic test_reset();
    clr = 1'b0;
    a_if.rd_req = 1'b0; a_if.wr_req = 1'b0; a_if.mem_ready = 1'b0;
    b_if.rd_req = 1'b0; b_if.wr_req = 1'b0; b_if.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== V_IDLE) begin errors++; $display("FAIL reset_outs_a: got %b want %b", obs_a, V_IDLE); end
    checks++;
    if (a_if.wait_cnt !== CW_A'(0)) begin errors++; $display("FAIL reset_cnt_a: got %0d want 0", a_if.wait_cnt); end
    checks++;
    if (obs_b !== V_IDLE) begin errors++; $display("FAIL reset_outs_b: got %b want %b", obs_b, V_IDLE); end
    @(negedge clk);
    clr = 1'b1;
  endtask

  // Drains the queue against instance A.
  task automatic test_seq_a(input string name);
    step_t st;
    int    k;
    k = 0;
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clk);
      a_if.rd_req = st.rd; a_if.wr_req = st.wr; a_if.mem_ready = st.rdy;
      @(posedge clk);
      #1;
      checks++;
      if (obs_a !== st.exp) begin
        errors++;
        $display("FAIL %s step %0d outputs: got %b want %b", name, k, obs_a, st.exp);
      end
      if (st.cnt >= 0) begin
        checks++;
        if (a_if.wait_cnt !== CW_A'(st.cnt)) begin
          errors++;
          $display("FAIL %s step %0d wait_cnt: got %0d want %0d", name, k, a_if.wait_cnt, st.cnt);
        end
      end
      k++;
    end
    @(negedge clk);
    a_if.rd_req = 1'b0; a_if.wr_req = 1'b0; a_if.mem_ready = 1'b0;
  endtask

  task automatic test_read();
    push(1, 0, 0, V_ADDR, 0);
    push(0, 0, 0, V_RDW, 0);
    push(0, 0, 1, V_RDC, 0);
    push(0, 0, 0, V_DONE, -1);
    push(0, 0, 0, V_IDLE, 0);
    test_seq_a("read_first_wait");
  endtask

  task automatic test_write();
    push(0, 1, 0, V_ADDR, 0);
    push(0, 0, 0, V_WRLD, 0);
    push(0, 0, 0, V_WRW, 0);
    push(0, 0, 0, V_WRW, 1);
    push(0, 0, 0, V_WRW, 2);
    push(0, 0, 0, V_WRW, 3);
    push(0, 0, 1, V_DONE, 3);
    push(0, 0, 0, V_IDLE, 0);
    test_seq_a("write_three_waits");
  endtask

  task automatic test_timeout();
    push(1, 0, 0, V_ADDR, 0);
    push(0, 0, 0, V_RDW, 0);
    push(0, 0, 0, V_RDW, 1);
    push(0, 0, 0, V_RDW, 2);
    push(0, 0, 0, V_RDW, 3);
    push(0, 0, 0, V_ERR, TO_A);
    push(0, 0, 0, V_IDLE, 0);
    push(0, 1, 0, V_ADDR, 0);
    push(0, 0, 0, V_WRLD, -1);
    push(0, 0, 0, V_WRW, 0);
    push(0, 0, 0, V_WRW, 1);
    push(0, 0, 0, V_WRW, 2);
    push(0, 0, 0, V_WRW, 3);
    push(0, 0, 0, V_ERR, TO_A);
    push(0, 0, 0, V_IDLE, 0);
    test_seq_a("timeout");
  endtask

  task automatic test_simultaneous();
    push(1, 1, 0, V_ADDR, 0);
    push(0, 1, 0, V_RDW, 0);
    push(0, 1, 0, V_RDW, 1);
    push(1, 1, 1, V_RDC, 1);
    push(0, 1, 0, V_DONE, -1);
    push(0, 1, 0, V_IDLE, 0);
    push(0, 0, 0, V_IDLE, 0);
    test_seq_a("rd_wr_same_cycle");
  endtask

  task automatic test_back_to_back();
    push(1, 0, 0, V_ADDR, 0);
    push(0, 0, 1, V_RDW, 0);
    push(0, 0, 1, V_RDC, 0);
    push(0, 0, 0, V_DONE, -1);
    push(0, 1, 0, V_IDLE, 0);
    push(0, 1, 0, V_ADDR, 0);
    push(0, 0, 0, V_WRLD, -1);
    push(0, 0, 1, V_WRW, 0);
    push(0, 0, 1, V_DONE, 0);
    push(0, 0, 0, V_IDLE, 0);
    test_seq_a("back_to_back");
  endtask

  task automatic test_reset_mid_access();
    push(1, 0, 0, V_ADDR, 0);
    push(0, 0, 0, V_RDW, 0);
    push(0, 0, 0, V_RDW, 1);
    test_seq_a("pre_abort");
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if (obs_a !== V_IDLE) begin errors++; $display("FAIL abort_outs: got %b want %b", obs_a, V_IDLE); end
    checks++;
    if (a_if.wait_cnt !== CW_A'(0)) begin errors++; $display("FAIL abort_cnt: got %0d want 0", a_if.wait_cnt); end
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    push(0, 0, 0, V_IDLE, 0);
    push(1, 0, 0, V_ADDR, 0);
    push(0, 0, 0, V_RDW, 0);
    push(0, 0, 1, V_RDC, 0);
    push(0, 0, 0, V_DONE, -1);
    push(0, 0, 0, V_IDLE, 0);
    test_seq_a("read_after_abort");
  endtask

  // Instance B: mem_ready on the last allowed wait cycle, then a real timeout.
  task automatic test_ready_at_limit();
    step_t st;
    int    k;
    push(1, 0, 0, V_ADDR, 0);
    push(0, 0, 0, V_RDW, 0);
    push(0, 0, 0, V_RDW, 1);
    push(0, 0, 1, V_RDC, 1);
    push(0, 0, 0, V_DONE, -1);
    push(0, 0, 0, V_IDLE, 0);
    push(1, 0, 0, V_ADDR, 0);
    push(0, 0, 0, V_RDW, 0);
    push(0, 0, 0, V_RDW, 1);
    push(0, 0, 0, V_ERR, TO_B);
    push(0, 0, 0, V_IDLE, 0);
    k = 0;
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clk);
      b_if.rd_req = st.rd; b_if.wr_req = st.wr; b_if.mem_ready = st.rdy;
      @(posedge clk);
      #1;
      checks++;
      if (obs_b !== st.exp) begin
        errors++;
        $display("FAIL ready_at_limit step %0d outputs: got %b want %b", k, obs_b, st.exp);
      end
      if (st.cnt >= 0) begin
        checks++;
        if (b_if.wait_cnt !== CW_B'(st.cnt)) begin
          errors++;
          $display("FAIL ready_at_limit step %0d wait_cnt: got %0d want %0d", k, b_if.wait_cnt, st.cnt);
        end
      end
      k++;
    end
    @(negedge clk);
    b_if.rd_req = 1'b0; b_if.wr_req = 1'b0; b_if.mem_ready = 1'b0;
  endtask

  // Test sequence.
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_access();
    test_ready_at_limit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
